// File: rtl/pa_risc_ppu.sv
// Five-stage PA-RISC control pipeline: fetch, decode, and control-only EX/MEM/WB stages.
// The program image comes in through ROM_INIT; build it from instructions.txt. Words left unset read as 0.
`timescale 1ns/1ps
module pa_risc_ppu #(
  parameter logic [31:0] ROM_INIT [0:63] = '{default: 32'h0}
) (
  input  logic clk,
  input  logic reset
);

  logic [31:0] PCFrontOut;
  logic [31:0] InstructionOut;
  logic [31:0] romWord;

  logic       SH, BL, L, RF_LE, PSW_EN, CO_EN, COMB;
  logic [1:0] RD_F, SR;
  logic [2:0] SOH_OP;
  logic [3:0] ALU_OP, RAM_CTRL;

  logic       EX_BL, EX_L, EX_RF_LE, EX_PSW_EN, EX_CO_EN, EX_COMB;
  logic [1:0] EX_SR;
  logic [2:0] EX_SOH_OP;
  logic [3:0] EX_ALU_OP, EX_RAM_CTRL;

  logic [3:0] MEM_RAM_CTRL_out;
  logic       MEM_L_out, MEM_RF_LE_out;
  logic       WB_RF_LE_out;

  logic [5:0] opcode, extOp;
  logic [2:0] subOp;

  assign romWord = ROM_INIT[PCFrontOut[7:2]];
  assign opcode  = InstructionOut[31:26];
  assign extOp   = InstructionOut[11:6];
  assign subOp   = InstructionOut[12:10];

  // Fetch: the PC free-runs with no redirection; IF/ID latches the ROM word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCFrontOut     <= 32'h0;
      InstructionOut <= 32'h0;
    end else begin
      PCFrontOut     <= PCFrontOut + 32'd4;
      InstructionOut <= romWord;
    end
  end

  // Decode: anything not recognised falls through with every control low.
  always_comb begin
    SH = 1'b0; RD_F = 2'b00; BL = 1'b0; SOH_OP = 3'b000; ALU_OP = 4'b0000;
    RAM_CTRL = 4'b0000; L = 1'b0; SR = 2'b00; RF_LE = 1'b0; PSW_EN = 1'b0;
    CO_EN = 1'b0; COMB = 1'b0;
    case (opcode)
      6'b000010: begin
        case (extOp)
          6'b011000: begin ALU_OP = 4'b0000; RF_LE = 1'b1; PSW_EN = 1'b1; end
          6'b011100: begin ALU_OP = 4'b0001; RF_LE = 1'b1; PSW_EN = 1'b1; CO_EN = 1'b1; end
          6'b101000: begin ALU_OP = 4'b0000; RF_LE = 1'b1; end
          6'b010000: begin ALU_OP = 4'b0010; RF_LE = 1'b1; PSW_EN = 1'b1; end
          6'b010100: begin ALU_OP = 4'b0011; RF_LE = 1'b1; PSW_EN = 1'b1; CO_EN = 1'b1; end
          6'b001001: begin ALU_OP = 4'b0100; RF_LE = 1'b1; end
          6'b001010: begin ALU_OP = 4'b0101; RF_LE = 1'b1; end
          6'b001000: begin ALU_OP = 4'b0110; RF_LE = 1'b1; end
          default: ;
        endcase
      end
      6'b110100: begin
        if (subOp == 3'b110 || subOp == 3'b111) begin
          SH = 1'b1; RD_F = 2'b01; ALU_OP = 4'b1010; RF_LE = 1'b1;
          SOH_OP = (subOp == 3'b110) ? 3'b100 : 3'b101;
        end
      end
      6'b110101: begin
        if (subOp == 3'b010) begin
          SH = 1'b1; RD_F = 2'b01; ALU_OP = 4'b1010; RF_LE = 1'b1; SOH_OP = 3'b110;
        end
      end
      6'b010010: begin RAM_CTRL = 4'b1010; L = 1'b1; RF_LE = 1'b1; SOH_OP = 3'b010; RD_F = 2'b01; end
      6'b010001: begin RAM_CTRL = 4'b1001; L = 1'b1; RF_LE = 1'b1; SOH_OP = 3'b010; RD_F = 2'b01; end
      6'b010000: begin RAM_CTRL = 4'b1000; L = 1'b1; RF_LE = 1'b1; SOH_OP = 3'b010; RD_F = 2'b01; end
      6'b011010: begin RAM_CTRL = 4'b1110; SR = 2'b01; SOH_OP = 3'b010; end
      6'b011001: begin RAM_CTRL = 4'b1101; SR = 2'b01; SOH_OP = 3'b010; end
      6'b011000: begin RAM_CTRL = 4'b1100; SR = 2'b01; SOH_OP = 3'b010; end
      6'b001101: begin RF_LE = 1'b1; SOH_OP = 3'b010; RD_F = 2'b01; end
      6'b001000: begin ALU_OP = 4'b1010; RF_LE = 1'b1; SOH_OP = 3'b010; RD_F = 2'b01; end
      6'b111010: begin BL = 1'b1; RF_LE = 1'b1; RD_F = 2'b10; end
      6'b100000,
      6'b100010: begin COMB = 1'b1; ALU_OP = 4'b0010; end
      6'b101101: begin RF_LE = 1'b1; PSW_EN = 1'b1; SOH_OP = 3'b001; RD_F = 2'b01; end
      6'b100101: begin ALU_OP = 4'b0010; RF_LE = 1'b1; PSW_EN = 1'b1; SOH_OP = 3'b001; RD_F = 2'b01; end
      default: ;
    endcase
  end

  // ID/EX, EX/MEM and MEM/WB control registers; no stalls or flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      EX_BL <= 1'b0; EX_SOH_OP <= 3'b000; EX_ALU_OP <= 4'b0000; EX_RAM_CTRL <= 4'b0000;
      EX_L <= 1'b0; EX_SR <= 2'b00; EX_RF_LE <= 1'b0; EX_PSW_EN <= 1'b0;
      EX_CO_EN <= 1'b0; EX_COMB <= 1'b0;
      MEM_RAM_CTRL_out <= 4'b0000; MEM_L_out <= 1'b0; MEM_RF_LE_out <= 1'b0;
      WB_RF_LE_out <= 1'b0;
    end else begin
      EX_BL <= BL; EX_SOH_OP <= SOH_OP; EX_ALU_OP <= ALU_OP; EX_RAM_CTRL <= RAM_CTRL;
      EX_L <= L; EX_SR <= SR; EX_RF_LE <= RF_LE; EX_PSW_EN <= PSW_EN;
      EX_CO_EN <= CO_EN; EX_COMB <= COMB;
      MEM_RAM_CTRL_out <= EX_RAM_CTRL; MEM_L_out <= EX_L; MEM_RF_LE_out <= EX_RF_LE;
      WB_RF_LE_out <= MEM_RF_LE_out;
    end
  end

endmodule

// File: tb/tb_pa_risc_ppu.sv
// Directed bench for pa_risc_ppu: walks a short program through the pipeline and probes stage controls.
`timescale 1ns/1ps
module tb_pa_risc_ppu;

  localparam logic [31:0] prog [0:63] = '{
    0: 32'h08000603,  // ADD   rd=3
    1: 32'h48050000,  // LDW   rt=5
    2: 32'h60050000,  // STB
    3: 32'h88000000,  // COMBF
    4: 32'hFC000000,  // opcode 111111 (undefined)
    5: 32'hE8000000,  // BL
    6: 32'h08000701,  // ADDC
    7: 32'hD0001800,  // EXTRU
    default: 32'h0
  };

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pa_risc_ppu #(.ROM_INIT(prog)) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle at the following falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;

    #2;
    checkOutput("rst_pc",     dut.PCFrontOut, 32'h0);
    checkOutput("rst_instr",  dut.InstructionOut, 32'h0);
    checkOutput("rst_alu",    {28'h0, dut.ALU_OP}, 32'h0);
    checkOutput("rst_rfle",   {31'h0, dut.RF_LE}, 32'h0);
    checkOutput("rst_ex_rfle", {31'h0, dut.EX_RF_LE}, 32'h0);
    checkOutput("rst_mem_ram", {28'h0, dut.MEM_RAM_CTRL_out}, 32'h0);
    checkOutput("rst_wb_rfle", {31'h0, dut.WB_RF_LE_out}, 32'h0);
    #1 reset = 1'b1;

    // edge 1: ADD in ID
    applyStimulus();
    checkOutput("e1_pc",      dut.PCFrontOut, 32'd4);
    checkOutput("e1_instr",   dut.InstructionOut, 32'h08000603);
    checkOutput("add_alu",    {28'h0, dut.ALU_OP}, 32'h0);
    checkOutput("add_rfle",   {31'h0, dut.RF_LE}, 32'h1);
    checkOutput("add_psw",    {31'h0, dut.PSW_EN}, 32'h1);
    checkOutput("add_rdf",    {30'h0, dut.RD_F}, 32'h0);

    // edge 2: LDW in ID, ADD in EX
    applyStimulus();
    checkOutput("e2_pc",      dut.PCFrontOut, 32'd8);
    checkOutput("ldw_ram",    {28'h0, dut.RAM_CTRL}, 32'hA);
    checkOutput("ldw_l",      {31'h0, dut.L}, 32'h1);
    checkOutput("ldw_rfle",   {31'h0, dut.RF_LE}, 32'h1);
    checkOutput("ldw_soh",    {29'h0, dut.SOH_OP}, 32'h2);
    checkOutput("ldw_rdf",    {30'h0, dut.RD_F}, 32'h1);
    checkOutput("ex_add_rfle", {31'h0, dut.EX_RF_LE}, 32'h1);
    checkOutput("ex_add_psw", {31'h0, dut.EX_PSW_EN}, 32'h1);
    checkOutput("ex_add_alu", {28'h0, dut.EX_ALU_OP}, 32'h0);

    // edge 3: STB in ID, LDW in EX, ADD in MEM
    applyStimulus();
    checkOutput("e3_pc",      dut.PCFrontOut, 32'd12);
    checkOutput("stb_ram",    {28'h0, dut.RAM_CTRL}, 32'hC);
    checkOutput("stb_l",      {31'h0, dut.L}, 32'h0);
    checkOutput("stb_rfle",   {31'h0, dut.RF_LE}, 32'h0);
    checkOutput("stb_sr",     {30'h0, dut.SR}, 32'h1);
    checkOutput("ex_ldw_ram", {28'h0, dut.EX_RAM_CTRL}, 32'hA);
    checkOutput("mem_add_rfle", {31'h0, dut.MEM_RF_LE_out}, 32'h1);

    // edge 4: COMBF in ID, LDW in MEM, ADD in WB
    applyStimulus();
    checkOutput("combf_comb", {31'h0, dut.COMB}, 32'h1);
    checkOutput("combf_alu",  {28'h0, dut.ALU_OP}, 32'h2);
    checkOutput("combf_rfle", {31'h0, dut.RF_LE}, 32'h0);
    checkOutput("mem_ldw_ram", {28'h0, dut.MEM_RAM_CTRL_out}, 32'hA);
    checkOutput("mem_ldw_l",  {31'h0, dut.MEM_L_out}, 32'h1);
    checkOutput("wb_add_rfle", {31'h0, dut.WB_RF_LE_out}, 32'h1);

    // edge 5: undefined opcode in ID, STB in MEM, LDW in WB
    applyStimulus();
    checkOutput("undef_ctrl", {18'h0, dut.SH, dut.RD_F, dut.BL, dut.SOH_OP, dut.ALU_OP,
                               dut.RAM_CTRL, dut.L, dut.SR, dut.RF_LE, dut.PSW_EN,
                               dut.CO_EN, dut.COMB}, 32'h0);
    checkOutput("mem_stb_ram", {28'h0, dut.MEM_RAM_CTRL_out}, 32'hC);
    checkOutput("wb_ldw_rfle", {31'h0, dut.WB_RF_LE_out}, 32'h1);

    // edge 6: BL in ID, STB in WB
    applyStimulus();
    checkOutput("bl_bl",      {31'h0, dut.BL}, 32'h1);
    checkOutput("bl_rdf",     {30'h0, dut.RD_F}, 32'h2);
    checkOutput("bl_rfle",    {31'h0, dut.RF_LE}, 32'h1);
    checkOutput("wb_stb_rfle", {31'h0, dut.WB_RF_LE_out}, 32'h0);

    // edge 7: ADDC in ID, BL in EX
    applyStimulus();
    checkOutput("addc_alu",   {28'h0, dut.ALU_OP}, 32'h1);
    checkOutput("addc_coen",  {31'h0, dut.CO_EN}, 32'h1);
    checkOutput("ex_bl_bl",   {31'h0, dut.EX_BL}, 32'h1);

    // edge 8: EXTRU in ID, ADDC in EX, BL in MEM
    applyStimulus();
    checkOutput("e8_pc",      dut.PCFrontOut, 32'd32);
    checkOutput("extru_sh",   {31'h0, dut.SH}, 32'h1);
    checkOutput("extru_soh",  {29'h0, dut.SOH_OP}, 32'h4);
    checkOutput("extru_alu",  {28'h0, dut.ALU_OP}, 32'hA);
    checkOutput("extru_rdf",  {30'h0, dut.RD_F}, 32'h1);
    checkOutput("ex_addc_coen", {31'h0, dut.EX_CO_EN}, 32'h1);
    checkOutput("mem_bl_rfle", {31'h0, dut.MEM_RF_LE_out}, 32'h1);

    // Mid-run reset between edges must clear state without a clock edge.
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_pc",      dut.PCFrontOut, 32'h0);
    checkOutput("mid_instr",   dut.InstructionOut, 32'h0);
    checkOutput("mid_ex_coen", {31'h0, dut.EX_CO_EN}, 32'h0);
    checkOutput("mid_ex_alu",  {28'h0, dut.EX_ALU_OP}, 32'h0);
    checkOutput("mid_mem",     {26'h0, dut.MEM_RAM_CTRL_out, dut.MEM_L_out, dut.MEM_RF_LE_out}, 32'h0);
    checkOutput("mid_wb",      {31'h0, dut.WB_RF_LE_out}, 32'h0);
    checkOutput("mid_id_rfle", {31'h0, dut.RF_LE}, 32'h0);

    // Hold across one rising edge, then restart from word 0.
    @(posedge clk);
    #1;
    checkOutput("hold_pc",     dut.PCFrontOut, 32'h0);
    #2 reset = 1'b1;
    applyStimulus();
    checkOutput("restart_pc",  dut.PCFrontOut, 32'd4);
    checkOutput("restart_instr", dut.InstructionOut, 32'h08000603);
    checkOutput("restart_ex",  {31'h0, dut.EX_RF_LE}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
